corfifo_gray_bin_pipe: RTL and testbench
========================================

CORFIFO_GRAY_BIN_PIPE -- requirements
Module: corfifo_gray_bin_pipe

Interface
REQ-001 The block SHALL have parameter ADDRWIDTH, default 3, meaning pointer MSB index; all code words are ADDRWIDTH+1 bits.
REQ-002 The block SHALL have parameter STAGES, default 2, meaning pipeline depth; legal range 1..4.
REQ-003 The block SHALL have parameter MODE, default 0, meaning conversion direction: 0 = gray-to-binary, 1 = binary-to-gray.
REQ-004 The block SHALL have parameter STEP_CHK, default 1, meaning single-bit-step checking is enabled (used only when MODE=0).
REQ-005 Port: clk  input  1  single clock; all state on rising edge.
REQ-006 Port: reset_n  input  1  asynchronous active-low reset.
REQ-007 Port: in_valid  input  1  in_data is valid this cycle.
REQ-008 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-009 Port: in_data  input  ADDRWIDTH+1  code word to convert.
REQ-010 Port: out_valid  output  1  out_data is valid.
REQ-011 Port: out_ready  input  1  consumer accepts out_data.
REQ-012 Port: out_data  output  ADDRWIDTH+1  converted word.
REQ-013 Port: out_step_err  output  1  this output word failed the step check.
REQ-014 Port: err_sticky  output  1  latched step-error flag.
REQ-015 Port: clr_err  input  1  synchronous clear of err_sticky.

Function
REQ-016 MODE=0: out_data[ADDRWIDTH] SHALL equal the input MSB, and each lower bit i SHALL equal out_data[i+1] XOR in_data[i].
REQ-017 MODE=1: out_data SHALL equal in_data XOR (in_data >> 1).
REQ-018 The XOR chain SHALL be partitioned across the STAGES registers; no single stage may hold more than ceil((ADDRWIDTH+1)/STAGES) chained XOR levels.
REQ-019 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-020 Latency SHALL be exactly STAGES cycles from input transfer to out_valid when out_ready is held high.
REQ-021 Each stage SHALL load when it is empty or when its downstream stage loads or transfers out in the same cycle; a bubble SHALL collapse.
REQ-022 in_ready SHALL be high exactly when stage 0 can load this cycle; sustained throughput SHALL be one word per cycle with out_ready high.
REQ-023 While out_valid && !out_ready, out_data and out_step_err SHALL hold stable, and no accepted word SHALL be dropped or duplicated.
REQ-024 Word order SHALL be preserved.
REQ-025 Step check (MODE=0, STEP_CHK=1): each accepted input SHALL be compared with the previous accepted input.
REQ-026 A Hamming distance greater than 1 SHALL flag the word; distance 0 or 1 SHALL NOT flag it.
REQ-027 The first word after reset SHALL NOT be checked.
REQ-028 The flag SHALL travel as sideband with its word and appear on out_step_err while that word is on out_data.
REQ-029 err_sticky SHALL set in the cycle after a flagged word's output transfer, and SHALL clear the cycle after clr_err is high.
REQ-030 If clr_err coincides with a flagged output transfer, err_sticky SHALL be set (set wins).
REQ-031 When MODE=1 or STEP_CHK=0, out_step_err and err_sticky SHALL be constant 0.
REQ-032 All-ones to all-zeros wrap SHALL convert normally; the gray wrap 100..0 to 000..0 is a one-bit step and SHALL NOT be flagged.

Reset
REQ-033 On reset_n low, all stage valid bits, out_valid, out_step_err, err_sticky and the previous-input register SHALL clear to 0 immediately.
REQ-034 in_ready SHALL be 1 after reset deassertion; out_data reset value SHALL be 0.
REQ-035 Reset asserted mid-stream SHALL discard all in-flight words; the first word after release SHALL be unchecked.

Verification
REQ-036 ADDRWIDTH=3, STAGES=2, MODE=0, out_ready=1: stream gray 0000,0001,0011,0010,...,1000 (16 words) -> binary 0..15 in order, each exactly 2 cycles after input, no step errors.
REQ-037 Same config: inputs 0001 then 0111 -> second output binary 0101 with out_step_err=1; err_sticky=1 the next cycle; clr_err pulse -> err_sticky=0.
REQ-038 out_ready held low 5 cycles during a 6-word burst -> in_ready drops after STAGES words are buffered; after release all 6 words arrive in order with no loss or duplication, and out_data holds stable while stalled.
REQ-039 MODE=1, ADDRWIDTH=7, STAGES=4: binary 0xA5 -> 0xF7 after 4 cycles; out_step_err stays 0.
REQ-040 Assert reset_n low with 2 words in flight -> out_valid=0 immediately; after release, input 1111 followed by 0000 -> no flag on the first word, flag on the second.

Source files
------------

// File: rtl/corfifo_gray_bin_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : corfifo_gray_bin_pipe
//  Description : Pipelined gray<->binary code converter with valid/ready
//                flow control, collapsing bubbles, and an optional
//                single-bit-step checker on the gray input stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module corfifo_gray_bin_pipe #(
    parameter int ADDRWIDTH = 3,
    parameter int STAGES    = 2,
    parameter int MODE      = 0,
    parameter int STEP_CHK  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDRWIDTH:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDRWIDTH:0]   out_data,
    output logic                 out_step_err,
    output logic                 err_sticky,
    input  logic                 clr_err
);

    localparam int           c_n      = ADDRWIDTH + 1;
    // XOR levels converted per stage, rounded up so the chain always fits
    localparam int           c_k      = (c_n + STAGES - 1) / STAGES;
    localparam bit           c_chk_en = (MODE == 0) && (STEP_CHK != 0);
    localparam logic [c_n-1:0] c_one  = {{(c_n-1){1'b0}}, 1'b1};

    // Partial conversion done by stage s. For gray-to-binary the register
    // between stages holds a mixed word: bits above the boundary are already
    // binary, bits below are still raw gray, so each stage extends the chain.
    function automatic logic [c_n-1:0] conv_stage(input logic [c_n-1:0] d,
                                                  input int s);
        logic [c_n-1:0] r;
        r = d;
        if (MODE == 0) begin
            for (int i = c_n - 2; i >= 0; i--) begin
                if (((c_n - 2 - i) / c_k) == s) begin
                    r[i] = r[i+1] ^ r[i];
                end
            end
        end else if (s == 0) begin
            r = d ^ (d >> 1);
        end
        return r;
    endfunction

    logic [c_n-1:0]    r_data  [STAGES];
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_err;
    logic [c_n-1:0]    r_prev;
    logic              r_prev_valid;
    logic              r_sticky;

    logic [c_n-1:0]    w_src_data [STAGES];
    logic [STAGES-1:0] w_src_valid;
    logic [STAGES-1:0] w_src_err;
    logic [c_n-1:0]    w_conv     [STAGES];
    logic [STAGES-1:0] w_ready;
    logic [c_n-1:0]    w_diff;
    logic              w_step_err;
    logic              w_in_fire;
    logic              w_out_fire;

    // Step check: more than one bit differing from the previous accepted word
    always_comb begin
        w_diff     = in_data ^ r_prev;
        w_step_err = c_chk_en && r_prev_valid && ((w_diff & (w_diff - c_one)) != '0);
    end

    // Stage ready: a stage can load if it or any stage downstream is empty,
    // or the output is being drained; this collapses bubbles.
    always_comb begin
        logic acc;
        acc     = out_ready;
        w_ready = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            acc        = acc | ~r_valid[s];
            w_ready[s] = acc;
        end
    end

    // Per-stage source selection and partial conversion
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            w_src_data[s]  = in_data;
            w_src_valid[s] = in_valid;
            w_src_err[s]   = w_step_err;
        end
        for (int s = 1; s < STAGES; s++) begin
            w_src_data[s]  = r_data[s-1];
            w_src_valid[s] = r_valid[s-1];
            w_src_err[s]   = r_err[s-1];
        end
        for (int s = 0; s < STAGES; s++) begin
            w_conv[s] = conv_stage(w_src_data[s], s);
        end
    end

    assign in_ready     = w_ready[0];
    assign w_in_fire    = in_valid && w_ready[0];
    assign out_valid    = r_valid[STAGES-1];
    assign out_data     = r_data[STAGES-1];
    assign out_step_err = r_err[STAGES-1];
    assign w_out_fire   = out_valid && out_ready;
    assign err_sticky   = r_sticky;

    // Pipeline registers: word, valid and step-error sideband move together
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_err   <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_data[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (w_ready[s]) begin
                    r_valid[s] <= w_src_valid[s];
                    if (w_src_valid[s]) begin
                        r_data[s] <= w_conv[s];
                        r_err[s]  <= w_src_err[s];
                    end
                end
            end
        end
    end

    // Previous accepted input for the step check; first word is unchecked
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_prev       <= in_data;
            r_prev_valid <= 1'b1;
        end
    end

    // Sticky error: set by a flagged output transfer, which beats a clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sticky <= 1'b0;
        end else if (c_chk_en && w_out_fire && out_step_err) begin
            r_sticky <= 1'b1;
        end else if (clr_err) begin
            r_sticky <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_corfifo_gray_bin_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_corfifo_gray_bin_pipe
//  Description : Directed, table-driven bench for corfifo_gray_bin_pipe
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_corfifo_gray_bin_pipe;

    typedef struct {
        logic [3:0] din;
        logic [3:0] dout;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       clr_err = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_ready, out_valid, out_step_err, err_sticky;
    logic [3:0] out_data;

    logic       m_in_valid = 1'b0;
    logic [7:0] m_in_data = '0;
    logic       m_in_ready, m_out_valid, m_out_step_err, m_err_sticky;
    logic [7:0] m_out_data;

    int total = 0;
    int bad   = 0;
    vec_t tbl [21];
    logic [3:0] sw [6];
    logic [3:0] sb [6];

    corfifo_gray_bin_pipe #(.ADDRWIDTH(3), .STAGES(2), .MODE(0), .STEP_CHK(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_step_err(out_step_err), .err_sticky(err_sticky), .clr_err(clr_err)
    );

    corfifo_gray_bin_pipe #(.ADDRWIDTH(7), .STAGES(4), .MODE(1), .STEP_CHK(1)) dut_b2g (
        .clk(clk), .reset_n(reset_n),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
        .out_valid(m_out_valid), .out_ready(1'b1), .out_data(m_out_data),
        .out_step_err(m_out_step_err), .err_sticky(m_err_sticky), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Stream table entries first..last back-to-back; each output is expected
    // exactly two cycles after its input cycle.
    task automatic apply(input int first, input int last);
        for (int k = first; k <= last + 1; k++) begin
            @(negedge clk);
            if (k <= last) begin
                in_valid = 1'b1;
                in_data  = tbl[k].din;
            end else begin
                in_valid = 1'b0;
            end
            #1 check("in_ready_stream", in_ready, 1);
            @(posedge clk);
            #1;
            if (k == first) begin
                check("latency_early", out_valid, 0);
            end else begin
                check("out_valid", out_valid, 1);
                check("out_data", out_data, tbl[k-1].dout);
                check("out_step_err", out_step_err, tbl[k-1].err);
            end
        end
    endtask

    task automatic clear_sticky();
        @(negedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        check("sticky_cleared", err_sticky, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, got;
        logic [3:0] hold;

        tbl[0]  = '{4'b0000, 4'd0,  1'b0};
        tbl[1]  = '{4'b0001, 4'd1,  1'b0};
        tbl[2]  = '{4'b0011, 4'd2,  1'b0};
        tbl[3]  = '{4'b0010, 4'd3,  1'b0};
        tbl[4]  = '{4'b0110, 4'd4,  1'b0};
        tbl[5]  = '{4'b0111, 4'd5,  1'b0};
        tbl[6]  = '{4'b0101, 4'd6,  1'b0};
        tbl[7]  = '{4'b0100, 4'd7,  1'b0};
        tbl[8]  = '{4'b1100, 4'd8,  1'b0};
        tbl[9]  = '{4'b1101, 4'd9,  1'b0};
        tbl[10] = '{4'b1111, 4'd10, 1'b0};
        tbl[11] = '{4'b1110, 4'd11, 1'b0};
        tbl[12] = '{4'b1010, 4'd12, 1'b0};
        tbl[13] = '{4'b1011, 4'd13, 1'b0};
        tbl[14] = '{4'b1001, 4'd14, 1'b0};
        tbl[15] = '{4'b1000, 4'd15, 1'b0};
        tbl[16] = '{4'b0000, 4'd0,  1'b0};   // gray wrap is a one-bit step
        tbl[17] = '{4'b0001, 4'd1,  1'b0};
        tbl[18] = '{4'b0111, 4'b0101, 1'b1}; // two bits changed
        tbl[19] = '{4'b1111, 4'b1010, 1'b0}; // first after reset: unchecked
        tbl[20] = '{4'b0000, 4'b0000, 1'b1};

        sw = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101};
        sb = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_step_err", out_step_err, 0);
        check("rst_err_sticky", err_sticky, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("rst_in_ready", in_ready, 1);

        // Binary-to-gray instance: four-cycle latency
        @(negedge clk);
        m_in_valid = 1'b1;
        m_in_data  = 8'hA5;
        #1 check("b2g_in_ready", m_in_ready, 1);
        for (int p = 1; p <= 4; p++) begin
            @(posedge clk);
            #1 m_in_valid = 1'b0;
            if (p < 4) begin
                check("b2g_latency_early", m_out_valid, 0);
            end else begin
                check("b2g_out_valid", m_out_valid, 1);
                check("b2g_out_data", m_out_data, 8'hF7);
                check("b2g_step_err", m_out_step_err, 0);
                check("b2g_sticky", m_err_sticky, 0);
            end
        end

        // Main gray-to-binary stream plus step-error word
        apply(0, 18);
        check("sticky_before_xfer", err_sticky, 0);
        @(posedge clk);
        #1;
        check("sticky_after_xfer", err_sticky, 1);
        check("drained_valid", out_valid, 0);
        clear_sticky();

        // Flagged output transfer coinciding with clr_err: set wins
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b0000;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("setwins_valid", out_valid, 1);
        check("setwins_data", out_data, 0);
        check("setwins_flag", out_step_err, 1);
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        check("sticky_set_wins", err_sticky, 1);
        clear_sticky();

        // Back-pressure: out_ready low for five cycles during a six-word burst
        sent = 0;
        got  = 0;
        hold = '0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid  = (sent < 6);
            if (sent < 6) in_data = sw[sent];
            #1;
            if (cyc <= 5) check("stall_in_ready", in_ready, (cyc < 2 || cyc >= 5));
            if (cyc == 2) begin
                hold = out_data;
                check("stall_head", out_data, sb[0]);
            end
            if (cyc >= 2 && cyc < 5) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold", out_data, hold);
                check("stall_flag", out_step_err, 0);
            end
            if (out_valid && out_ready) begin
                check("stall_order", out_data, sb[got]);
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
        end
        in_valid = 1'b0;
        check("stall_count", got, 6);
        @(negedge clk);
        #1 check("stall_no_dup", out_valid, 0);

        // Reset with two words in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'b0001;
        @(negedge clk);
        in_data   = 4'b0011;
        @(negedge clk);
        in_valid  = 1'b0;
        #1 check("inflight_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sticky", err_sticky, 0);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        apply(19, 20);
        check("post_rst_sticky_before", err_sticky, 0);
        @(posedge clk);
        #1 check("post_rst_sticky_after", err_sticky, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
